obj_line_scanner: RTL and testbench
===================================

Name: obj_line_scanner

Overview:
Downstream consumer of the object RAM filled by the object/palette DMA stage. At each scanline start it walks the active object list in object RAM, tests every entry against the current line, and pushes a per-line draw descriptor for each hit into a small output FIFO. The sprite line renderer drains that FIFO.

Parameters:
FIFO_DEPTH, 8, descriptor FIFO entries (power of two).
MAX_PER_LINE, 32, maximum descriptors emitted per line before overflow.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
ce  in  1  clock enable; all state advances only when ce=1
line_start  in  1  one-clk pulse; begins a scan for `line`
line  in  9  scanline number, latched on line_start
obj_count  in  8  number of active entries (0 = none)
obj_bank  in  1  object RAM bank (address bit 10)
obj_addr  out  11  object RAM read address {obj_bank, idx[7:0], word[1:0]}
obj_din  in  16  object RAM read data, valid one ce after the address
busy  out  1  scan in progress
line_overflow  out  1  sticky for the line: MAX_PER_LINE reached
desc_valid  out  1  FIFO head valid
desc_ready  in  1  consumer accepts head when desc_valid & desc_ready & ce
desc_code  out  16  tile code for this line
desc_row  out  4  pixel row within tile
desc_x  out  10  x position
desc_color  out  7  palette select
desc_prio  out  1  priority
desc_flipx  out  1  horizontal flip
desc_width  out  2  width select, passed through

Behaviour:
- Entry layout: w0 = y[8:0], hsel[10:9], wsel[12:11]; w1 = code; w2 = color[6:0], prio[7], flipx[8], flipy[9]; w3 = x[9:0].
- Reset: state IDLE, busy=0, line_overflow=0, FIFO empty (desc_valid=0), obj_addr=0, all desc_* = 0.
- States: IDLE -> FETCH (word 0..3) -> EVAL -> PUSH -> FETCH or DONE -> IDLE.
- line_start (any state, ce not required): latch line; flush FIFO; idx=0; clear overflow and hit counter; go FETCH. If busy, the current scan is aborted with no partial push. If obj_count=0, go DONE.
- FETCH: one address per ce. Data for word n is captured on the ce after its address. Four words take 5 ce, then EVAL.
- EVAL: row = (line - y) mod 512, 9-bit. h = 1<<hsel tiles (1/2/4/8). Hit iff row < 16*h.
  - tr = row[6:4]; if flipy, tr = h-1-tr.
  - desc_code = code + tr (16-bit wrap); desc_row = flipy ? ~row[3:0] : row[3:0].
  - Miss: go to next entry.
- PUSH: waits while FIFO full (stall; no entry dropped). On push, hit counter +1. If counter reaches MAX_PER_LINE, set line_overflow and go DONE.
- Next entry: idx+1. Go DONE when idx+1 == obj_count.
- DONE: one ce, then IDLE, busy=0. FIFO continues draining.
- Simultaneous push and pop on a full FIFO is allowed (count unchanged). Pop with desc_valid=0 is ignored.
- y wraparound: y=500, line=4 gives row=16, which hits when h>=2.

Decomposition:
- Package obj_scan_pkg: descriptor packed struct, word index constants (W_Y, W_CODE, W_ATTR, W_X), state enum.
- One sub-module, obj_desc_fifo: sync FIFO, FIFO_DEPTH, flush input, full/empty, ce-qualified push/pop.

Test Plan:
- obj_count=1, entry y=100 hsel=0 code=0x1230; line_start line=100 -> one descriptor code=0x1230 row=0; line=115 -> row=15; line=116 -> none.
- y=50 hsel=2 flipy=1 code=0x0400, line=70 -> row=20, tr=1 flipped to 2 -> code=0x0402, desc_row=0xB.
- y=500 hsel=1, line=4 -> hit, code+1, row=0; line=20 -> miss.
- 40 entries all hitting line 10, desc_ready=1 -> exactly 32 descriptors, line_overflow=1, busy low after DONE.
- desc_ready=0, 12 hits, FIFO_DEPTH=8 -> scan stalls with 8 queued and busy=1; raise desc_ready -> all 12 delivered in entry order.
- line_start mid-scan after 3 pushes -> FIFO flushed (desc_valid=0 next clk), scan restarts at idx 0 for the new line.

Source files
------------

// File: rtl/obj_scan_pkg.sv
// Shared types and helpers for the object line scanner: entry layout, draw
// descriptor, FSM encoding and the per-line hit/descriptor arithmetic.
package obj_scan_pkg;

    // Word offsets of one object entry in object RAM.
    localparam logic [1:0] W_Y    = 2'd0;
    localparam logic [1:0] W_CODE = 2'd1;
    localparam logic [1:0] W_ATTR = 2'd2;
    localparam logic [1:0] W_X    = 2'd3;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_EVAL  = 3'd2;
    localparam logic [2:0] S_PUSH  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef struct packed {
        logic [8:0]  y;
        logic [1:0]  hsel;
        logic [1:0]  wsel;
        logic [15:0] code;
        logic [6:0]  color;
        logic        prio;
        logic        flipx;
        logic        flipy;
        logic [9:0]  x;
    } obj_entry_t;

    typedef struct packed {
        logic [15:0] code;
        logic [3:0]  row;
        logic [9:0]  x;
        logic [6:0]  color;
        logic        prio;
        logic        flipx;
        logic [1:0]  width;
    } obj_desc_t;

    // Row of the object hit by this line; wraps mod 512 so objects near y=511
    // continue onto the top lines.
    function automatic logic [8:0] obj_row(input logic [8:0] line, input obj_entry_t e);
        return line - e.y;
    endfunction

    function automatic logic obj_hit(input logic [8:0] line, input obj_entry_t e);
        return obj_row(line, e) < (9'd16 << e.hsel);
    endfunction

    function automatic obj_desc_t make_desc(input logic [8:0] line, input obj_entry_t e);
        logic [6:0] row;
        logic [2:0] tr;
        logic [2:0] h_m1;
        obj_desc_t  d;
        row  = 7'(obj_row(line, e));
        tr   = row[6:4];
        h_m1 = 3'((4'd1 << e.hsel) - 4'd1);
        if (e.flipy) tr = h_m1 - tr;
        d.code  = e.code + {13'd0, tr};
        d.row   = e.flipy ? ~row[3:0] : row[3:0];
        d.x     = e.x;
        d.color = e.color;
        d.prio  = e.prio;
        d.flipx = e.flipx;
        d.width = e.wsel;
        return d;
    endfunction

endpackage

// File: rtl/obj_desc_fifo.sv
// Synchronous descriptor FIFO with flush; push and pop only act on ce.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module obj_desc_fifo
    import obj_scan_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      ce,
    input  logic      flush,
    input  logic      push,
    input  obj_desc_t push_data,
    input  logic      pop,
    output obj_desc_t head,
    output logic      empty,
    output logic      push_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

    obj_desc_t     mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push_fire;
    logic          pop_fire;

    assign empty      = (count == '0);
    assign full       = (count == CNT_FULL);
    assign push_ready = ~full | (pop & ~empty);
    assign push_fire  = ce & push & push_ready & ~flush;
    assign pop_fire   = ce & pop & ~empty & ~flush;
    assign head       = empty ? '0 : mem[rd_ptr];

    // NOTE: storage has no reset; empty gates the head so stale words never leak out.
    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obj_line_scanner.sv
// Per-scanline object scanner: walks the active object list, tests each entry
// against the latched line and queues a draw descriptor for every hit.
module obj_line_scanner
    import obj_scan_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int MAX_PER_LINE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        line_start,
    input  logic [8:0]  line,
    input  logic [7:0]  obj_count,
    input  logic        obj_bank,
    output logic [10:0] obj_addr,
    input  logic [15:0] obj_din,
    output logic        busy,
    output logic        line_overflow,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [15:0] desc_code,
    output logic [3:0]  desc_row,
    output logic [9:0]  desc_x,
    output logic [6:0]  desc_color,
    output logic        desc_prio,
    output logic        desc_flipx,
    output logic [1:0]  desc_width
);

    localparam int HW = $clog2(MAX_PER_LINE + 1);
    localparam logic [HW-1:0] HIT_ONE = HW'(1);
    localparam logic [HW-1:0] HIT_MAX = HW'(MAX_PER_LINE);

    logic [2:0]    state;
    logic [8:0]    line_q;
    logic [7:0]    count_q;
    logic [7:0]    idx;
    logic [2:0]    wcnt;
    logic [HW-1:0] hits;
    obj_entry_t    entry;
    obj_desc_t     desc_q;
    obj_desc_t     head;
    logic          fifo_empty;
    logic          push_ready;
    logic          entry_hit;
    logic          last_entry;
    logic          advance;

    assign entry_hit  = obj_hit(line_q, entry);
    assign last_entry = ({1'b0, idx} + 9'd1) == {1'b0, count_q};
    // Move to the next entry after a miss, or after a push that did not hit the cap.
    assign advance    = (state == S_EVAL && !entry_hit) ||
                        (state == S_PUSH && push_ready && (hits + HIT_ONE) != HIT_MAX);
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            line_q        <= '0;
            count_q       <= '0;
            idx           <= '0;
            wcnt          <= '0;
            hits          <= '0;
            entry         <= '0;
            desc_q        <= '0;
            obj_addr      <= '0;
            line_overflow <= 1'b0;
        end else if (line_start) begin
            line_q        <= line;
            count_q       <= obj_count;
            idx           <= '0;
            wcnt          <= '0;
            hits          <= '0;
            line_overflow <= 1'b0;
            obj_addr      <= {obj_bank, 8'd0, W_Y};
            state         <= (obj_count == 8'd0) ? S_DONE : S_FETCH;
        end else if (ce) begin
            case (state)
                S_FETCH: begin
                    // Data returned now belongs to the address issued one ce earlier.
                    if (wcnt != 3'd0) begin
                        case (wcnt[1:0] - 2'd1)
                            W_Y: begin
                                entry.y    <= obj_din[8:0];
                                entry.hsel <= obj_din[10:9];
                                entry.wsel <= obj_din[12:11];
                            end
                            W_CODE: entry.code <= obj_din;
                            W_ATTR: begin
                                entry.color <= obj_din[6:0];
                                entry.prio  <= obj_din[7];
                                entry.flipx <= obj_din[8];
                                entry.flipy <= obj_din[9];
                            end
                            W_X:     entry.x <= obj_din[9:0];
                            default: ;
                        endcase
                    end
                    if (wcnt == 3'd4) begin
                        state <= S_EVAL;
                    end else begin
                        if (wcnt != 3'd3) obj_addr <= {obj_bank, idx, wcnt[1:0] + 2'd1};
                        wcnt <= wcnt + 3'd1;
                    end
                end
                S_EVAL: begin
                    if (entry_hit) begin
                        desc_q <= make_desc(line_q, entry);
                        state  <= S_PUSH;
                    end
                end
                S_PUSH: begin
                    if (push_ready) begin
                        hits <= hits + HIT_ONE;
                        if ((hits + HIT_ONE) == HIT_MAX) begin
                            line_overflow <= 1'b1;
                            state         <= S_DONE;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (last_entry) begin
                    state <= S_DONE;
                end else begin
                    idx      <= idx + 8'd1;
                    wcnt     <= '0;
                    obj_addr <= {obj_bank, idx + 8'd1, W_Y};
                    state    <= S_FETCH;
                end
            end
        end
    end

    obj_desc_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .ce         (ce),
        .flush      (line_start),
        .push       (state == S_PUSH),
        .push_data  (desc_q),
        .pop        (desc_ready),
        .head       (head),
        .empty      (fifo_empty),
        .push_ready (push_ready)
    );

    assign desc_valid = ~fifo_empty;
    assign desc_code  = head.code;
    assign desc_row   = head.row;
    assign desc_x     = head.x;
    assign desc_color = head.color;
    assign desc_prio  = head.prio;
    assign desc_flipx = head.flipx;
    assign desc_width = head.width;

endmodule

// File: tb/tb_obj_line_scanner.sv
// Self-checking bench for obj_line_scanner: directed vector table, corner-case
// sequences and randomized scans against an arithmetic reference model.
module tb_obj_line_scanner;

    localparam int MAX = 32;

    typedef logic [40:0] dword_t;
    typedef struct {
        int y; int hsel; int flipy; int flipx; int code; int x; int ln;
        int exp_hit; int exp_code; int exp_row;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, ce, line_start, desc_ready;
    logic [8:0]  line;
    logic [7:0]  obj_count;
    logic        obj_bank;
    logic [10:0] obj_addr;
    logic [15:0] obj_din;
    logic        busy, line_overflow, desc_valid;
    logic [15:0] desc_code;
    logic [3:0]  desc_row;
    logic [9:0]  desc_x;
    logic [6:0]  desc_color;
    logic        desc_prio, desc_flipx;
    logic [1:0]  desc_width;

    logic [15:0] mem [2048];
    int          checks = 0;
    int          errors = 0;
    dword_t      got_q[$];
    dword_t      exp_q[$];
    bit          exp_ovf;
    bit          ce_rand = 1'b0;
    int          ready_mode = 0;
    vec_t        vecs[11];

    always #5 clk = ~clk;

    obj_line_scanner dut (
        .clk(clk), .reset(reset), .ce(ce), .line_start(line_start), .line(line),
        .obj_count(obj_count), .obj_bank(obj_bank), .obj_addr(obj_addr), .obj_din(obj_din),
        .busy(busy), .line_overflow(line_overflow), .desc_valid(desc_valid),
        .desc_ready(desc_ready), .desc_code(desc_code), .desc_row(desc_row),
        .desc_x(desc_x), .desc_color(desc_color), .desc_prio(desc_prio),
        .desc_flipx(desc_flipx), .desc_width(desc_width)
    );

    // Object RAM: registered read, one ce of latency.
    always @(posedge clk) if (ce) obj_din <= mem[obj_addr];

    // Sole driver of ce and desc_ready.
    initial begin
        ce = 1'b1;
        desc_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ce = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            desc_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
        end
    end

    // Record every descriptor the consumer actually accepts.
    always @(negedge clk) begin
        if (!reset && ce && desc_valid && desc_ready && !line_start)
            got_q.push_back({desc_code, desc_row, desc_x, desc_color, desc_prio, desc_flipx, desc_width});
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic dword_t pack(input int code, input int row, input int x, input int color,
                                    input int prio, input int flipx, input int width);
        dword_t d;
        d = {16'(code), 4'(row), 10'(x), 7'(color), 1'(prio), 1'(flipx), 2'(width)};
        return d;
    endfunction

    task automatic put_entry(input int bank, input int idx, input int y, input int hsel,
                             input int wsel, input int code, input int color, input int prio,
                             input int flipx, input int flipy, input int x);
        int base;
        base = bank * 1024 + idx * 4;
        mem[base]     = 16'((wsel << 11) | (hsel << 9) | (y & 511));
        mem[base + 1] = 16'(code);
        mem[base + 2] = 16'((flipy << 9) | (flipx << 8) | (prio << 7) | (color & 127));
        mem[base + 3] = 16'(x & 1023);
    endtask

    // Reference: scan entries in order, apply the line/row rules, stop at MAX hits.
    task automatic build_expected(input int ln, input int bank, input int cnt);
        exp_q.delete();
        exp_ovf = 1'b0;
        for (int i = 0; i < cnt && !exp_ovf; i++) begin
            int base, y, hsel, wsel, code, color, prio, flipx, flipy, x, row, h, tr;
            logic [15:0] w0, w2;
            base  = bank * 1024 + i * 4;
            w0    = mem[base];
            w2    = mem[base + 2];
            y     = int'(w0[8:0]);
            hsel  = int'(w0[10:9]);
            wsel  = int'(w0[12:11]);
            code  = int'(mem[base + 1]);
            color = int'(w2[6:0]);
            prio  = int'(w2[7]);
            flipx = int'(w2[8]);
            flipy = int'(w2[9]);
            x     = int'(mem[base + 3]) % 1024;
            row   = (ln - y + 512) % 512;
            h     = 1 << hsel;
            if (row < 16 * h) begin
                tr = row / 16;
                if (flipy != 0) tr = h - 1 - tr;
                exp_q.push_back(pack((code + tr) % 65536, (flipy != 0) ? 15 - row % 16 : row % 16,
                                     x, color, prio, flipx, wsel));
                if (exp_q.size() == MAX) exp_ovf = 1'b1;
            end
        end
    endtask

    task automatic start_line(input int ln, input int cnt, input int bank);
        got_q.delete();
        line       = 9'(ln);
        obj_count  = 8'(cnt);
        obj_bank   = 1'(bank);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic finish_line();
        int n;
        n = 0;
        while (busy && n < 4000) begin tick(); n++; end
        check("scan_done", busy, 0);
        ready_mode = 1;
        n = 0;
        while (desc_valid && n < 4000) begin tick(); n++; end
        check("fifo_drained", desc_valid, 0);
    endtask

    task automatic compare_scan(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_desc%0d", name, i), got_q[i], exp_q[i]);
        check({name, "_ovf"}, line_overflow, exp_ovf);
    endtask

    initial begin
        reset = 1'b1; line_start = 1'b0; line = '0; obj_count = '0; obj_bank = 1'b0;
        foreach (mem[i]) mem[i] = '0;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_valid", desc_valid, 0);
        check("rst_addr", obj_addr, 0);
        check("rst_ovf", line_overflow, 0);
        check("rst_desc", {desc_code, desc_row, desc_x, desc_color, desc_prio, desc_flipx, desc_width}, 0);
        reset = 1'b0;
        tick();

        // Single-entry vectors: {y, hsel, flipy, flipx, code, x, line, hit, code, row}.
        vecs = '{
            '{100, 0, 0, 0, 'h1230,   37, 100, 1, 'h1230,  0},
            '{100, 0, 0, 0, 'h1230,   37, 115, 1, 'h1230, 15},
            '{100, 0, 0, 0, 'h1230,   37, 116, 0,      0,  0},
            '{ 50, 2, 1, 0, 'h0400,  512,  70, 1, 'h0402, 11},
            '{500, 1, 0, 1, 'h2000, 1023,   4, 1, 'h2001,  0},
            '{500, 1, 0, 0, 'h2000,    0,  20, 0,      0,  0},
            '{  0, 3, 0, 1, 'hFFFC,  800, 127, 1, 'h0003, 15},
            '{  0, 3, 0, 0, 'hFFFC,  800, 128, 0,      0,  0},
            '{ 10, 0, 1, 0, 'h0777,    5,  10, 1, 'h0777, 15},
            '{511, 0, 0, 0, 'h0010,    9,   0, 1, 'h0010,  1},
            '{ 20, 3, 1, 0, 'h0100,    3,  20, 1, 'h0107, 15}
        };
        ready_mode = 1;
        for (int i = 0; i < 11; i++) begin
            put_entry(0, 0, vecs[i].y, vecs[i].hsel, i % 4, vecs[i].code, (i * 9) % 128, i % 2,
                      vecs[i].flipx, vecs[i].flipy, vecs[i].x);
            start_line(vecs[i].ln, 1, 0);
            finish_line();
            check($sformatf("vec%0d_count", i), got_q.size(), vecs[i].exp_hit);
            if (vecs[i].exp_hit != 0 && got_q.size() > 0)
                check($sformatf("vec%0d_desc", i), got_q[0],
                      pack(vecs[i].exp_code, vecs[i].exp_row, vecs[i].x, (i * 9) % 128, i % 2,
                           vecs[i].flipx, i % 4));
            check($sformatf("vec%0d_ovf", i), line_overflow, 0);
        end

        // No active objects.
        start_line(33, 0, 0);
        finish_line();
        check("empty_list_count", got_q.size(), 0);

        // 40 hits on one line: capped at MAX with overflow set.
        for (int i = 0; i < 40; i++) put_entry(1, i, 10, 0, 1, 'h0500 + i, i, 0, 0, 0, i * 7);
        ready_mode = 1;
        start_line(10, 40, 1);
        finish_line();
        build_expected(10, 1, 40);
        compare_scan("ovf");
        check("ovf_cap", got_q.size(), MAX);

        // Consumer stalled: scan must hold with the FIFO full, then deliver everything in order.
        for (int i = 0; i < 12; i++) put_entry(0, i, 10, 0, 0, 'h0100 + i, i, 1, 1, 0, i * 3);
        ready_mode = 0;
        tick();
        start_line(10, 12, 0);
        repeat (150) tick();
        check("stall_busy", busy, 1);
        check("stall_valid", desc_valid, 1);
        check("stall_head", desc_code, 'h0100);
        check("stall_nopop", got_q.size(), 0);
        ready_mode = 1;
        finish_line();
        build_expected(10, 0, 12);
        compare_scan("stall");

        // Restart mid-scan: FIFO flushed, new line scanned from entry 0.
        for (int i = 0; i < 10; i++)
            put_entry(1, i, (i % 2 == 0) ? 10 : 200, 3, 2, ((i % 2 == 0) ? 'h0200 : 'h0300) + i,
                      i + 40, 0, 0, i % 3 == 0, 100 + i);
        ready_mode = 0;
        tick();
        start_line(10, 10, 1);
        for (int n = 0; n < 100 && !desc_valid; n++) tick();
        check("abort_prefill", desc_valid, 1);
        repeat (28) tick();
        start_line(205, 10, 1);
        check("abort_flush", desc_valid, 0);
        check("abort_busy", busy, 1);
        ready_mode = 1;
        finish_line();
        build_expected(205, 1, 10);
        compare_scan("abort");

        // Randomized scans with random ce and consumer back-pressure.
        ce_rand = 1'b1;
        for (int it = 0; it < 25; it++) begin
            int bank, cnt, ln;
            bank = int'($urandom_range(0, 1));
            cnt  = int'($urandom_range(0, 40));
            ln   = int'($urandom_range(0, 511));
            for (int i = 0; i < cnt; i++) begin
                int r;
                r = int'($urandom_range(0, 140));
                put_entry(bank, i, (ln - r + 512) % 512, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                          int'($urandom_range(0, 127)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                          int'($urandom_range(0, 1023)));
            end
            ready_mode = 2;
            tick();
            start_line(ln, cnt, bank);
            finish_line();
            build_expected(ln, bank, cnt);
            compare_scan($sformatf("rnd%0d", it));
        end
        ce_rand = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
